// File: rtl/vx_stream_pkg.sv
// Shared definitions for the valid/ready stream blocks: default sizing,
// the occupancy-count width helper and the occupancy update encoding.
package vx_stream_pkg;

  localparam int unsigned VX_FIFO_DEPTH    = 4;
  localparam int unsigned VX_FIFO_ALM_FULL = VX_FIFO_DEPTH - 1;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  function automatic int unsigned clog2_cnt(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vx_fifo_ctrl.sv
// Pointer / occupancy controller for vx_stream_fifo: owns rd/wr pointers,
// count and the registered full, almost-full and valid flags.
module vx_fifo_ctrl
  import vx_stream_pkg::*;
#(
  parameter int unsigned DEPTH    = VX_FIFO_DEPTH,
  parameter int unsigned ALM_FULL = DEPTH - 1,
  localparam int unsigned PTRW    = $clog2(DEPTH),
  localparam int unsigned CNTW    = clog2_cnt(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            valid_in,
  input  logic            ready_out,
  output logic            ready_in,
  output logic            valid_out,
  output logic            push,
  output logic            pop,
  output logic [PTRW-1:0] rd_ptr,
  output logic [PTRW-1:0] wr_ptr,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            alm_full
);

  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            alm_full_q, alm_full_d;
  logic            valid_q, valid_d;
  cnt_op_e         cnt_op;

  // A full FIFO refuses input even when popping; the freed slot opens next cycle.
  assign ready_in = ~full_q & ~flush;
  assign push     = valid_in & ready_in;
  assign pop      = valid_q & ready_out & ~flush;

  always_comb begin
    cnt_op = CNT_HOLD;
    if (push && !pop)      cnt_op = CNT_INC;
    else if (pop && !push) cnt_op = CNT_DEC;

    count_d = count_q;
    case (cnt_op)
      CNT_INC: count_d = count_q + CNTW'(1);
      CNT_DEC: count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    wr_ptr_d   = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    full_d     = (count_d == CNTW'(DEPTH));
    alm_full_d = (count_d >= CNTW'(ALM_FULL));
    valid_d    = (count_d != '0);

    if (flush) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      full_d     = 1'b0;
      alm_full_d = 1'b0;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      alm_full_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      alm_full_q <= alm_full_d;
      valid_q    <= valid_d;
    end
  end

  assign rd_ptr    = rd_ptr_q;
  assign wr_ptr    = wr_ptr_q;
  assign count     = count_q;
  assign full      = full_q;
  assign alm_full  = alm_full_q;
  assign valid_out = valid_q;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("vx_fifo_ctrl: DEPTH must be a power of two >= 2");
  end
  if ((ALM_FULL < 1) || (ALM_FULL > DEPTH)) begin : g_bad_alm_full
    $error("vx_fifo_ctrl: ALM_FULL must be within 1..DEPTH");
  end

  a_no_push_full : assert property (@(posedge clk) disable iff (reset) push |-> !full_q);
  a_no_pop_empty : assert property (@(posedge clk) disable iff (reset) pop |-> valid_q);

endmodule

// File: rtl/vx_stream_fifo.sv
// Elastic valid/ready stream FIFO with DEPTH entries, optional registered
// head output, synchronous flush and occupancy / full / almost-full status.
module vx_stream_fifo
  import vx_stream_pkg::*;
#(
  parameter int unsigned DATAW    = 1,
  parameter int unsigned DEPTH    = VX_FIFO_DEPTH,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned ALM_FULL = DEPTH - 1,
  parameter int unsigned PASSTHRU = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic [DATAW-1:0]              data_in,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [DATAW-1:0]              data_out,
  output logic [clog2_cnt(DEPTH)-1:0]   count,
  output logic                          full,
  output logic                          alm_full
);

  localparam int unsigned PTRW = $clog2(DEPTH);

  if (PASSTHRU != 0) begin : g_pass
    assign ready_in  = ready_out;
    assign valid_out = valid_in;
    assign data_out  = data_in;
    assign count     = '0;
    assign full      = 1'b0;
    assign alm_full  = 1'b0;
  end else begin : g_fifo
    logic             push, pop;
    logic [PTRW-1:0]  rd_ptr, wr_ptr;
    logic [DATAW-1:0] mem_q [DEPTH];

    vx_fifo_ctrl #(
      .DEPTH    (DEPTH),
      .ALM_FULL (ALM_FULL)
    ) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .ready_in  (ready_in),
      .valid_out (valid_out),
      .push      (push),
      .pop       (pop),
      .rd_ptr    (rd_ptr),
      .wr_ptr    (wr_ptr),
      .count     (count),
      .full      (full),
      .alm_full  (alm_full)
    );

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr] <= data_in;
    end

    if (OUT_REG != 0) begin : g_out_reg
      logic [DATAW-1:0] head_q, head_d;
      logic [PTRW-1:0]  rd_next;

      assign rd_next = rd_ptr + PTRW'(1);

      // Head mirrors the entry at rd_ptr; with a single entry left the
      // successor is still in flight on data_in rather than in storage.
      always_comb begin
        head_d = head_q;
        if (push && (count == '0)) head_d = data_in;
        else if (pop)              head_d = (count > 1) ? mem_q[rd_next] : data_in;
      end

      always_ff @(posedge clk) begin
        head_q <= head_d;
      end

      assign data_out = head_q;
    end else begin : g_out_mem
      assign data_out = mem_q[rd_ptr];
    end
  end

endmodule

// File: tb/tb_vx_stream_fifo.sv
// Directed + random bench for vx_stream_fifo (DEPTH=4, both OUT_REG variants)
// against a queue-based reference model.
module tb_vx_stream_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 4;
  localparam int unsigned AF = 3;

  logic          clk = 1'b0;
  logic          reset, flush, valid_in, ready_out;
  logic [DW-1:0] data_in;

  logic          ready_in0, valid_out0, full0, alm_full0;
  logic [DW-1:0] data_out0;
  logic [2:0]    count0;
  logic          ready_in1, valid_out1, full1, alm_full1;
  logic [DW-1:0] data_out1;
  logic [2:0]    count1;

  int errors = 0;
  int checks = 0;
  logic known = 1'b0;
  logic [DW-1:0] mq[$];

  always #5 clk = ~clk;

  vx_stream_fifo #(.DATAW(DW), .DEPTH(DP), .OUT_REG(0), .ALM_FULL(AF), .PASSTHRU(0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_in(ready_in0),
    .data_in(data_in), .valid_out(valid_out0), .ready_out(ready_out), .data_out(data_out0),
    .count(count0), .full(full0), .alm_full(alm_full0)
  );

  vx_stream_fifo #(.DATAW(DW), .DEPTH(DP), .OUT_REG(1), .ALM_FULL(AF), .PASSTHRU(0)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_in(ready_in1),
    .data_in(data_in), .valid_out(valid_out1), .ready_out(ready_out), .data_out(data_out1),
    .count(count1), .full(full1), .alm_full(alm_full1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    chk("r0_ready_in",  int'(ready_in0),  int'(sz != DP && !flush));
    chk("r0_valid_out", int'(valid_out0), int'(sz != 0));
    chk("r0_count",     int'(count0),     sz);
    chk("r0_full",      int'(full0),      int'(sz == DP));
    chk("r0_alm_full",  int'(alm_full0),  int'(sz >= AF));
    chk("r1_ready_in",  int'(ready_in1),  int'(sz != DP && !flush));
    chk("r1_valid_out", int'(valid_out1), int'(sz != 0));
    chk("r1_count",     int'(count1),     sz);
    chk("r1_full",      int'(full1),      int'(sz == DP));
    chk("r1_alm_full",  int'(alm_full1),  int'(sz >= AF));
    if (sz != 0) begin
      chk("r0_data_out", int'(data_out0), int'(mq[0]));
      chk("r1_data_out", int'(data_out1), int'(mq[0]));
    end
  endtask

  // One clock: drive after the falling edge, check, then advance the model at the rising edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic rst);
    logic do_push, do_pop;
    @(negedge clk);
    valid_in  = v;
    data_in   = d;
    ready_out = r;
    flush     = f;
    reset     = rst;
    #1;
    if (known) check_all();
    @(posedge clk);
    if (rst || f) begin
      mq.delete();
      if (rst) known = 1'b1;
    end else begin
      do_push = v && (mq.size() < DP);
      do_pop  = r && (mq.size() > 0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(d);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0; data_in = '0;
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    // Fill to full, then offer more with the consumer stalled
    for (int i = 0; i < 4; i++) step(1, 8'hA1 + 8'(i), 0, 0, 0);
    step(1, 8'hA5, 0, 0, 0);
    // Pop from full while offering a push: push must be refused
    step(1, 8'hB0, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);

    // Streaming throughput
    for (int i = 0; i < 100; i++) step(1, 8'(i), 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Pointer wrap bursts
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + b * 3 + i), 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
    end
    step(0, 8'h00, 0, 0, 0);

    // Flush at count 3 with a simultaneous push
    for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0);
    step(1, 8'hEE, 1, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    step(1, 8'h11, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Reset mid-stream at count 2
    step(1, 8'hD0, 0, 0, 0);
    step(1, 8'hD1, 0, 0, 0);
    step(1, 8'h77, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);
    step(1, 8'h05, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 500; i++) begin
      logic v, r, f, rst;
      v   = ($urandom_range(0, 3) != 0);
      r   = (i < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 79) == 0);
      step(v, 8'($urandom), r, f, rst);
    end
    step(0, 8'h00, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
